// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream multiplexer with a registered output stage.
// Fixed-select or round-robin arbitration; packets hold the grant until their last beat.
module stream_mux_rr #(
    parameter int N    = 4,
    parameter int W    = 4,
    parameter int SELW = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mode,
    input  logic [SELW-1:0]   sel,
    input  logic [N-1:0]      in_valid,
    input  logic [N-1:0]      in_last,
    input  logic [N*W-1:0]    in_data,
    output logic [N-1:0]      in_ready,
    output logic              out_valid,
    output logic [W-1:0]      out_data,
    output logic              out_last,
    output logic [SELW-1:0]   out_src,
    input  logic              out_ready
);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t          state, state_next;
    logic [SELW-1:0] lock_ch, rr_ptr, cand, rr_cand;
    logic            cand_ok, rr_found, load, xfer, cand_last;
    logic [W-1:0]    cand_data;

    assign load = !out_valid || out_ready;

    // Round-robin search starts one past the channel that last finished a packet.
    always_comb begin
        rr_cand  = '0;
        rr_found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!rr_found && in_valid[SELW'((int'(rr_ptr) + k) % N)]) begin
                rr_found = 1'b1;
                rr_cand  = SELW'((int'(rr_ptr) + k) % N);
            end
        end
    end

    always_comb begin
        cand       = '0;
        cand_ok    = 1'b0;
        state_next = state;
        in_ready   = '0;
        if (state == LOCK) begin
            cand    = lock_ch;
            cand_ok = in_valid[lock_ch];
        end else if (mode) begin
            cand    = rr_cand;
            cand_ok = rr_found;
        end else begin
            cand    = sel;
            cand_ok = (int'(sel) < N) && in_valid[sel];
        end
        cand_data = in_data[int'(cand)*W +: W];
        cand_last = in_last[cand];
        xfer      = load && cand_ok;
        if (xfer) begin
            in_ready[cand] = 1'b1;
            if (state == IDLE && !cand_last) begin
                state_next = LOCK;
            end else if (state == LOCK && cand_last) begin
                state_next = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A new beat may overwrite the output register in the same cycle it drains.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            out_src   <= '0;
            lock_ch   <= '0;
            rr_ptr    <= SELW'(N - 1);
        end else begin
            if (xfer) begin
                out_valid <= 1'b1;
                out_data  <= cand_data;
                out_last  <= cand_last;
                out_src   <= cand;
                if (state == IDLE) begin
                    lock_ch <= cand;
                end
                if (cand_last) begin
                    rr_ptr <= cand;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: per-channel beat sources feed the mux and
// expected {src,data,last} beats are queued by each scenario and popped on output handshakes.
module tb_stream_mux_rr;

    localparam int N    = 4;
    localparam int W    = 4;
    localparam int SELW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            mode = 1'b1;
    logic [SELW-1:0] sel = '0;
    logic [N-1:0]    in_valid = '0;
    logic [N-1:0]    in_last = '0;
    logic [N*W-1:0]  in_data = '0;
    logic [N-1:0]    in_ready;
    logic            out_valid;
    logic [W-1:0]    out_data;
    logic            out_last;
    logic [SELW-1:0] out_src;
    logic            out_ready = 1'b1;

    int total = 0;
    int bad   = 0;

    logic [4:0]      beats [N][32];
    int              head [N];
    int              tail [N];
    logic [N-1:0]    gate;
    logic [N-1:0]    seen_ready;
    logic [6:0]      expq [$];

    stream_mux_rr #(.N(N), .W(W)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_valid(in_valid), .in_last(in_last), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_src(out_src),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    task automatic clear_all();
        for (int i = 0; i < N; i++) begin
            head[i] = 0;
            tail[i] = 0;
        end
        gate = '1;
        expq.delete();
    endtask

    task automatic push_beat(input int ch, input logic [3:0] data, input logic last);
        beats[ch][tail[ch]] = {last, data};
        tail[ch]++;
    endtask

    task automatic expect_beat(input logic [1:0] src, input logic [3:0] data, input logic last);
        expq.push_back({src, data, last});
    endtask

    // One clock: present source heads, sample at negedge, advance accepted sources.
    task automatic step();
        logic [N-1:0] acc;
        logic [6:0]   exp_b;
        logic [6:0]   got;
        for (int i = 0; i < N; i++) begin
            if (gate[i] && head[i] < tail[i]) begin
                in_valid[i]       = 1'b1;
                in_data[i*W +: W] = beats[i][head[i]][3:0];
                in_last[i]        = beats[i][head[i]][4];
            end else begin
                in_valid[i]       = 1'b0;
                in_data[i*W +: W] = '0;
                in_last[i]        = 1'b0;
            end
        end
        @(negedge clk);
        seen_ready = in_ready;
        acc = in_valid & in_ready;
        if (out_valid && out_ready) begin
            got = {out_src, out_data, out_last};
            total++;
            if (expq.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_beat: got src/data/last=%h required none", got);
            end else begin
                exp_b = expq.pop_front();
                if (got !== exp_b) begin
                    bad++;
                    $display("[TB] FAIL out_beat: got src=%0d data=%h last=%b required src=%0d data=%h last=%b",
                             got[6:5], got[4:1], got[0], exp_b[6:5], exp_b[4:1], exp_b[0]);
                end
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) head[i]++;
        end
    endtask

    task automatic run_until_empty(input int budget);
        int n = 0;
        while (expq.size() != 0 && n < budget) begin
            step();
            n++;
        end
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain_timeout: got %0d beats outstanding required 0", expq.size());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        clear_all();
        out_ready = 1'b1;
        in_valid  = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_all();
        #3;
        total++;
        if ({out_valid, out_data, out_last, out_src} !== 8'h00) begin
            bad++;
            $display("[TB] FAIL reset_state: got valid=%b data=%h last=%b src=%0d required all zero",
                     out_valid, out_data, out_last, out_src);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_fixed();
        logic [N-1:0] any_ready;
        do_reset();
        mode = 1'b0;
        sel  = 2'd2;
        push_beat(2, 4'hA, 1'b1);
        push_beat(0, 4'h3, 1'b1);
        expect_beat(2'd2, 4'hA, 1'b1);
        step();
        total++;
        if (out_valid !== 1'b1 || out_data !== 4'hA || out_src !== 2'd2) begin
            bad++;
            $display("[TB] FAIL fixed_latency: got valid=%b data=%h src=%0d required 1 a 2",
                     out_valid, out_data, out_src);
        end
        sel = 2'd3;
        head[0] = tail[0];
        push_beat(2, 4'h5, 1'b1);
        any_ready = '0;
        for (int k = 0; k < 3; k++) begin
            step();
            any_ready |= seen_ready;
        end
        total++;
        if (any_ready !== 4'b0000 || out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL fixed_sel3: got in_ready=%b valid=%b required 0000 0", any_ready, out_valid);
        end
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("[TB] FAIL fixed_drain: got %0d outstanding required 0", expq.size());
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        mode = 1'b1;
        for (int i = 0; i < N; i++) begin
            push_beat(i, 4'(i + 1), 1'b1);
            expect_beat(2'(i), 4'(i + 1), 1'b1);
        end
        push_beat(0, 4'h1, 1'b1);
        expect_beat(2'd0, 4'h1, 1'b1);
        for (int k = 0; k < 6; k++) step();
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("[TB] FAIL rr_throughput: got %0d outstanding after 6 cycles required 0", expq.size());
        end
        run_until_empty(10);
    endtask

    task automatic test_packet_lock();
        logic [N-1:0] any_ready;
        do_reset();
        mode = 1'b1;
        push_beat(0, 4'h9, 1'b1);
        expect_beat(2'd0, 4'h9, 1'b1);
        run_until_empty(10);
        push_beat(1, 4'h5, 1'b0);
        push_beat(1, 4'h6, 1'b0);
        push_beat(1, 4'h7, 1'b1);
        push_beat(0, 4'h2, 1'b1);
        push_beat(3, 4'h4, 1'b1);
        expect_beat(2'd1, 4'h5, 1'b0);
        expect_beat(2'd1, 4'h6, 1'b0);
        expect_beat(2'd1, 4'h7, 1'b1);
        expect_beat(2'd3, 4'h4, 1'b1);
        expect_beat(2'd0, 4'h2, 1'b1);
        step();
        step();
        gate[1] = 1'b0;
        any_ready = '0;
        for (int k = 0; k < 3; k++) begin
            step();
            any_ready |= seen_ready;
        end
        total++;
        if (any_ready !== 4'b0000 || out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL lock_bubble: got in_ready=%b valid=%b required 0000 0", any_ready, out_valid);
        end
        gate[1] = 1'b1;
        run_until_empty(20);
    endtask

    task automatic test_back_pressure();
        do_reset();
        mode = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            push_beat(2, 4'(i), 1'b1);
            expect_beat(2'd2, 4'(i), 1'b1);
        end
        step();
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (out_valid !== 1'b1 || out_data !== 4'h1 || seen_ready !== 4'b0000) begin
                bad++;
                $display("[TB] FAIL bp_hold: got valid=%b data=%h in_ready=%b required 1 1 0000",
                         out_valid, out_data, seen_ready);
            end
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) step();
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("[TB] FAIL bp_resume: got %0d outstanding after 4 cycles required 0", expq.size());
        end
        run_until_empty(10);
    endtask

    task automatic test_mode_switch();
        do_reset();
        mode = 1'b1;
        push_beat(1, 4'h8, 1'b0);
        push_beat(1, 4'h9, 1'b0);
        push_beat(1, 4'hA, 1'b1);
        push_beat(2, 4'hB, 1'b1);
        expect_beat(2'd1, 4'h8, 1'b0);
        expect_beat(2'd1, 4'h9, 1'b0);
        expect_beat(2'd1, 4'hA, 1'b1);
        expect_beat(2'd2, 4'hB, 1'b1);
        step();
        mode = 1'b0;
        sel  = 2'd2;
        run_until_empty(20);
        mode = 1'b1;
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        mode = 1'b1;
        push_beat(0, 4'h3, 1'b1);
        expect_beat(2'd0, 4'h3, 1'b1);
        run_until_empty(10);
        push_beat(2, 4'hC, 1'b0);
        push_beat(2, 4'hD, 1'b0);
        push_beat(2, 4'hE, 1'b1);
        expect_beat(2'd2, 4'hC, 1'b0);
        step();
        step();
        total++;
        if (out_valid !== 1'b1 || out_data !== 4'hD) begin
            bad++;
            $display("[TB] FAIL mid_before_reset: got valid=%b data=%h required 1 d", out_valid, out_data);
        end
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({out_valid, out_data, out_last, out_src} !== 8'h00) begin
            bad++;
            $display("[TB] FAIL async_reset: got valid=%b data=%h last=%b src=%0d required all zero",
                     out_valid, out_data, out_last, out_src);
        end
        clear_all();
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_beat(1, 4'h5, 1'b1);
        push_beat(0, 4'h6, 1'b1);
        expect_beat(2'd0, 4'h6, 1'b1);
        expect_beat(2'd1, 4'h5, 1'b1);
        run_until_empty(20);
    endtask

    initial begin
        clear_all();
        test_reset();
        test_fixed();
        test_round_robin();
        test_packet_lock();
        test_back_pressure();
        test_mode_switch();
        test_reset_mid_packet();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
